wb_queue: RTL and testbench
===========================

// Module: wb_queue
// PURPOSE
// Writeback buffer that produces the write-port traffic for the register file.
// - Accepts results from execute/load units over a valid/ready handshake.
// - Queues up to DEPTH pending writes in order and drains one per enabled cycle
//   onto the register file write port (address, data, write-enable).
// - Offers youngest-match lookup on two read addresses, so operand reads can see
//   results still waiting in the queue.
// PARAMETERS
// dtype    16               data width; matches register file word width
// nregs    8                number of architectural registers
// addr_len $clog2(nregs)    register address width
// DEPTH    4                queue entries; power of 2, >= 2
// PORTS
// clock       in   1              rising-edge clock
// reset       in   1              synchronous, active-low reset
// in_valid    in   1              producer has a result
// in_ready    out  1              queue can accept; transfer when in_valid & in_ready
// in_address  in   addr_len       destination register
// in_data     in   dtype          result value
// drain_en    in   1              permission to write the register file this cycle
// wr_en       out  1              register file write enable
// wr_address  out  addr_len       register file write address
// wr_data     out  dtype          register file write data
// rX_address  in   addr_len       lookup address X (same as register file read X)
// rY_address  in   addr_len       lookup address Y
// rX_hit      out  1              pending write to rX_address exists
// rX_fwd      out  dtype          youngest pending data for rX_address
// rY_hit      out  1              pending write to rY_address exists
// rY_fwd      out  dtype          youngest pending data for rY_address
// count       out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
// - Storage: circular buffer with head/tail pointers and a count; all state
//   updates on the rising edge of clock.
// - Reset (reset==0 at an edge): pointers = 0, count = 0, all entry valid bits
//   cleared, data contents don't-care.
// - While reset is low: in_ready = 0 and wr_en = 0.
// - Reset mid-operation: all pending writes are discarded and never reach the
//   register file.
// - in_ready = reset & (count != DEPTH).
//   - A pop in the same cycle does NOT free a slot for a push; a full queue
//     accepts nothing that cycle.
// - Push: on in_valid & in_ready with in_address != 0, the entry is written at
//   tail, tail++ (wraps modulo DEPTH), count++.
// - Push to register 0: the handshake still completes (in_ready honoured), but
//   nothing is stored and count is unchanged. Register 0 is hard zero.
// - Drain outputs:
//   - wr_en = reset & drain_en & (count != 0).
//   - wr_address and wr_data come from the head entry; they are 0 when the
//     queue is empty.
//   - Outputs are combinational from registered state.
// - Pop: whenever wr_en is high, head++ (wrap) and count-- at that edge.
// - Simultaneous push and pop: count unchanged, both pointers advance.
//   - Queue empty: no pop, so a new entry cannot bypass to wr_* in the same
//     cycle.
// - Latency: result accepted at edge N appears on wr_* in cycle N+1 (empty
//   queue); write completes at edge N+1 if drain_en is high.
// - Ordering: strict FIFO; two writes to the same register reach the register
//   file in arrival order.
// - Lookup: rX_hit = 1 iff some held entry has address == rX_address and
//   rX_address != 0.
//   - rX_fwd = data of the youngest matching entry, i.e. closest to tail.
//   - rX_fwd = 0 when there is no hit.
//   - rY identical.
//   - Purely combinational on held entries; an entry being pushed this cycle is
//     not visible until the next cycle.
//   - The entry being popped this cycle is still visible this cycle.
// - count range 0..DEPTH; never exceeds DEPTH and never underflows.
// CONFIGURATION
// - WB_BYPASS_EN defined: lookup logic built as described above.
// - WB_BYPASS_EN undefined: no comparators; rX_hit = rY_hit = 0,
//   rX_fwd = rY_fwd = 0. Consumers must stall on count != 0.
// - The queue and drain logic are identical in both builds.
// TESTING
// 1. Reset: reset=0 two cycles -> count=0, wr_en=0, in_ready=0. Release ->
//    in_ready=1, rX_hit=0.
// 2. Single write: push addr 3, data 16'hBEEF, drain_en=0 -> count=1,
//    wr_en=0. Raise drain_en -> wr_en=1, wr_address=3, wr_data=BEEF for one
//    cycle, then count=0.
// 3. Full/backpressure (DEPTH=4): drain_en=0, push 4 entries -> count=4,
//    in_ready=0. A 5th in_valid is held. drain_en=1 with in_valid -> pop that
//    cycle, push accepted only on the following edge. Order preserved.
// 4. Register 0: push addr 0, data FFFF -> handshake completes, count
//    unchanged, no wr_en. Lookup rX_address=0 -> rX_hit=0.
// 5. Bypass (WB_BYPASS_EN): push (5,0x1111) then (5,0x2222), drain_en=0,
//    rX_address=5 -> rX_hit=1, rX_fwd=0x2222. Drain one -> still 0x2222.
//    Drain second -> rX_hit=0. Without the macro, rX_hit stays 0 throughout.
// 6. Wrap and reset mid-run: 10 random push/pop cycles crossing the pointer
//    wrap match the reference model. Assert reset with count=3 -> no further
//    wr_en; count=0 after release.

Source files
------------

// File: rtl/wb_queue_if.sv
// Writeback queue bus: producer handshake, register-file write port, operand lookup.
// master = producer/consumer side, slave = the queue.
interface wb_queue_if #(
  parameter int dtype = 16,
  parameter int nregs = 8,
  parameter int DEPTH = 4
);
  localparam int addr_len = $clog2(nregs);
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic                in_valid;
  logic                in_ready;
  logic [addr_len-1:0] in_address;
  logic [dtype-1:0]    in_data;
  logic                drain_en;
  logic                wr_en;
  logic [addr_len-1:0] wr_address;
  logic [dtype-1:0]    wr_data;
  logic [addr_len-1:0] rX_address;
  logic [addr_len-1:0] rY_address;
  logic                rX_hit;
  logic [dtype-1:0]    rX_fwd;
  logic                rY_hit;
  logic [dtype-1:0]    rY_fwd;
  logic [CNT_W-1:0]    count;

  modport master (
    output in_valid, in_address, in_data, drain_en, rX_address, rY_address,
    input  in_ready, wr_en, wr_address, wr_data, rX_hit, rX_fwd, rY_hit, rY_fwd, count
  );
  modport slave (
    input  in_valid, in_address, in_data, drain_en, rX_address, rY_address,
    output in_ready, wr_en, wr_address, wr_data, rX_hit, rX_fwd, rY_hit, rY_fwd, count
  );
endinterface

// File: rtl/wb_queue.sv
// In-order register-file writeback queue with optional youngest-match operand lookup.
// Define WB_BYPASS_EN to build the rX/rY lookup comparators; otherwise hit/fwd tie to 0.
module wb_queue #(
  parameter int dtype = 16,
  parameter int nregs = 8,
  parameter int DEPTH = 4
) (
  input logic       clock,
  input logic       reset,
  wb_queue_if.slave bus
);
  localparam int addr_len = $clog2(nregs);
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  typedef struct packed {
    logic [addr_len-1:0] addr;
    logic [dtype-1:0]    data;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, empty, push, pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  // Readiness ignores a same-cycle pop, so a full queue never accepts.
  assign bus.in_ready = reset & ~full;
  assign push = bus.in_valid & bus.in_ready & (bus.in_address != '0);
  assign pop  = reset & bus.drain_en & ~empty;

  assign bus.wr_en      = pop;
  assign bus.wr_address = empty ? '0 : ent_q[head_q].addr;
  assign bus.wr_data    = empty ? '0 : ent_q[head_q].data;
  assign bus.count      = cnt_q;

  always_comb begin
    head_d = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d = push ? tail_q + PTR_W'(1) : tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) ent_q[tail_q] <= '{addr: bus.in_address, data: bus.in_data};
  end

`ifdef WB_BYPASS_EN
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] idx;

  always_comb begin
    vld_d = vld_q;
    if (pop)  vld_d[head_q] = 1'b0;
    if (push) vld_d[tail_q] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    bus.rX_hit = 1'b0;
    bus.rX_fwd = '0;
    bus.rY_hit = 1'b0;
    bus.rY_fwd = '0;
    idx        = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (vld_q[idx] && bus.rX_address != '0 && ent_q[idx].addr == bus.rX_address) begin
        bus.rX_hit = 1'b1;
        bus.rX_fwd = ent_q[idx].data;
      end
      if (vld_q[idx] && bus.rY_address != '0 && ent_q[idx].addr == bus.rY_address) begin
        bus.rY_hit = 1'b1;
        bus.rY_fwd = ent_q[idx].data;
      end
    end
  end
`else
  assign bus.rX_hit = 1'b0;
  assign bus.rX_fwd = '0;
  assign bus.rY_hit = 1'b0;
  assign bus.rY_fwd = '0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: queue-based reference model, directed phases then random traffic.
module tb_wb_queue;
  localparam int DW = 16, NR = 8, DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  wb_queue_if #(.dtype(DW), .nregs(NR), .DEPTH(DEPTH)) bus ();
  wb_queue #(.dtype(DW), .nregs(NR), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t  sb[$];          // pending writes, oldest first
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   started = 1'b0;
  logic exp_ready = 1'b0;
  logic exp_wen;
  logic eh;
  logic [15:0] ef;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Youngest pending write to a nonzero register wins.
  function automatic void look(input logic [2:0] a, output logic h, output logic [15:0] f);
    h = 1'b0;
    f = '0;
    if (a != 0) foreach (sb[i]) if (sb[i].a == a) begin h = 1'b1; f = sb[i].d; end
`ifndef WB_BYPASS_EN
    h = 1'b0;
    f = '0;
`endif
  endfunction

  always @(posedge clock) begin
    started <= 1'b1;
    if (!reset) sb.delete();
    else if (bus.in_valid && exp_ready && bus.in_address != 0)
      sb.push_back('{a: bus.in_address, d: bus.in_data});
  end

  always @(negedge clock) begin
    if (started) begin
      exp_ready = reset && (sb.size() != DEPTH);
      exp_wen   = reset && bus.drain_en && (sb.size() != 0);
      chk("count", 32'(bus.count), 32'(sb.size()));
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      chk("wr_en", 32'(bus.wr_en), 32'(exp_wen));
      if (sb.size() != 0) begin
        chk("wr_address", 32'(bus.wr_address), 32'(sb[0].a));
        chk("wr_data", 32'(bus.wr_data), 32'(sb[0].d));
      end else begin
        chk("wr_address_empty", 32'(bus.wr_address), 32'd0);
        chk("wr_data_empty", 32'(bus.wr_data), 32'd0);
      end
      look(bus.rX_address, eh, ef);
      chk("rX_hit", 32'(bus.rX_hit), 32'(eh));
      chk("rX_fwd", 32'(bus.rX_fwd), 32'(ef));
      look(bus.rY_address, eh, ef);
      chk("rY_hit", 32'(bus.rY_hit), 32'(eh));
      chk("rY_fwd", 32'(bus.rY_fwd), 32'(ef));
      if (exp_wen) void'(sb.pop_front());
    end
  end

  task automatic drive(input bit v, input logic [2:0] a, input logic [15:0] d, input bit dr);
    bus.in_valid   = v;
    bus.in_address = a;
    bus.in_data    = d;
    bus.drain_en   = dr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_address = '0;
    bus.in_data    = '0;
    bus.drain_en   = 1'b0;
    bus.rX_address = 3'd3;
    bus.rY_address = 3'd0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // single write, held then drained
    drive(1, 3, 16'hBEEF, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);

    // fill, backpressure a held fifth write, then drain in order
    for (int i = 1; i <= 4; i++) drive(1, 3'(i), 16'(16'h1000 + i), 0);
    drive(1, 6, 16'h6666, 0);
    drive(1, 6, 16'h6666, 1);
    drive(1, 6, 16'h6666, 0);
    repeat (6) drive(0, 0, 0, 1);

    // register 0 is never stored
    bus.rX_address = 3'd0;
    drive(1, 0, 16'hFFFF, 0);
    drive(0, 0, 0, 1);

    // youngest-match lookup across drains
    bus.rX_address = 3'd5;
    bus.rY_address = 3'd5;
    drive(1, 5, 16'h1111, 0);
    drive(1, 5, 16'h2222, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);

    // random traffic crossing the pointer wrap many times
    for (int i = 0; i < 300; i++) begin
      bus.rX_address = 3'($urandom_range(0, 7));
      bus.rY_address = 3'($urandom_range(0, 7));
      drive(($urandom % 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom), ($urandom % 2) == 1);
    end

    // reset with three pending writes discards them
    repeat (6) drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 3'(i + 2), 16'(16'hA000 + i), 0);
    drive(0, 0, 0, 0);
    bus.in_valid = 1'b0;
    bus.drain_en = 1'b1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) drive(0, 0, 0, 1);
    for (int i = 0; i < 60; i++)
      drive(($urandom % 2) == 1, 3'($urandom_range(0, 7)), 16'($urandom), ($urandom % 3) == 0);
    repeat (6) drive(0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
